// File: rtl/bullet_hit_detector.sv
// Bullet/alien collision detector.
// Watches the raster for the first pixel in a frame where an opaque bullet pixel
// covers an opaque alien pixel. At frame end it reports that alien's grid position,
// adds to the score, and then ignores overlaps for a configurable number of frames.
//
// Ports:
//   Pclk        pixel clock
//   rst_n       synchronous active-low reset
//   xx, yy      current raster position
//   aactive     active-pixel strobe
//   BSpriteOn   bullet sprite covers this pixel
//   dataout2    bullet pixel value
//   ASpriteOn   alien sprite covers this pixel
//   alien_px    alien pixel value
//   alien_col   grid column of the alien under this pixel
//   alien_row   grid row of the alien under this pixel
//   hit         one-cycle pulse on a confirmed hit
//   bullet_rst  one-cycle request to return the bullet to the launcher
//   hit_col     column of the last hit
//   hit_row     row of the last hit
//   score       accumulated score, saturating
//   busy        high while overlaps are being ignored after a hit
module bullet_hit_detector #(
    parameter logic [7:0]  TRANSPARENT    = 8'h00,
    parameter int unsigned POINTS         = 10,
    parameter int unsigned HOLDOFF_FRAMES = 2
) (
    input  logic        Pclk,
    input  logic        rst_n,
    input  logic [9:0]  xx,
    input  logic [9:0]  yy,
    input  logic        aactive,
    input  logic        BSpriteOn,
    input  logic [7:0]  dataout2,
    input  logic        ASpriteOn,
    input  logic [7:0]  alien_px,
    input  logic [2:0]  alien_col,
    input  logic [1:0]  alien_row,
    output logic        hit,
    output logic        bullet_rst,
    output logic [2:0]  hit_col,
    output logic [1:0]  hit_row,
    output logic [15:0] score,
    output logic        busy
);

    localparam int unsigned X_W     = 10;
    localparam int unsigned Y_W     = 10;
    localparam int unsigned COL_W   = 3;
    localparam int unsigned ROW_W   = 2;
    localparam int unsigned SCORE_W = 16;
    localparam int unsigned CNT_W   = 4;

    localparam logic [X_W-1:0]     X_LAST    = X_W'(639);
    localparam logic [Y_W-1:0]     Y_LAST    = Y_W'(479);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [SCORE_W:0]   POINTS_X  = (SCORE_W+1)'(POINTS);
    localparam logic [CNT_W-1:0]   HOLD_LOAD = CNT_W'(HOLDOFF_FRAMES);

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        REPORT  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               pending, pending_nxt;
    logic [COL_W-1:0]   cand_col, cand_col_nxt;
    logic [ROW_W-1:0]   cand_row, cand_row_nxt;
    logic [CNT_W-1:0]   frame_cnt, frame_cnt_nxt;
    logic               hit_nxt, bullet_rst_nxt, busy_nxt;
    logic [COL_W-1:0]   hit_col_nxt;
    logic [ROW_W-1:0]   hit_row_nxt;
    logic [SCORE_W-1:0] score_nxt;

    logic               overlap_c;
    logic               frame_end_c;
    logic               first_c;
    logic [SCORE_W:0]   score_sum_c;
    logic [SCORE_W-1:0] score_sat_c;

    // Pixel-level collision and frame boundary decode
    assign overlap_c   = aactive && BSpriteOn && ASpriteOn &&
                         (dataout2 != TRANSPARENT) && (alien_px != TRANSPARENT);
    assign frame_end_c = (xx == X_LAST) && (yy == Y_LAST);
    assign first_c     = overlap_c && !pending;

    // One spare bit catches overflow so the score can clamp
    assign score_sum_c = {1'b0, score} + POINTS_X;
    assign score_sat_c = score_sum_c[SCORE_W] ? SCORE_MAX : score_sum_c[SCORE_W-1:0];

    // State register
    always_ff @(posedge Pclk) begin
        if (!rst_n) begin
            state <= SCAN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next register values; outputs register the value for the
    // coming cycle so hit/bullet_rst are high exactly while the FSM sits in REPORT
    always_comb begin
        state_nxt      = state;
        pending_nxt    = pending;
        cand_col_nxt   = cand_col;
        cand_row_nxt   = cand_row;
        frame_cnt_nxt  = frame_cnt;
        hit_nxt        = 1'b0;
        bullet_rst_nxt = 1'b0;
        busy_nxt       = 1'b0;
        hit_col_nxt    = hit_col;
        hit_row_nxt    = hit_row;
        score_nxt      = score;

        unique case (state)
            SCAN: begin
                if (first_c) begin
                    pending_nxt  = 1'b1;
                    cand_col_nxt = alien_col;
                    cand_row_nxt = alien_row;
                end
                // An overlap on the frame-end pixel itself still belongs to this frame
                if (frame_end_c && (pending || overlap_c)) begin
                    state_nxt      = REPORT;
                    hit_nxt        = 1'b1;
                    bullet_rst_nxt = 1'b1;
                    hit_col_nxt    = first_c ? alien_col : cand_col;
                    hit_row_nxt    = first_c ? alien_row : cand_row;
                    score_nxt      = score_sat_c;
                end
            end
            REPORT: begin
                state_nxt     = HOLDOFF;
                pending_nxt   = 1'b0;
                frame_cnt_nxt = HOLD_LOAD;
                busy_nxt      = 1'b1;
            end
            HOLDOFF: begin
                busy_nxt = 1'b1;
                if (frame_end_c) begin
                    if (frame_cnt <= CNT_W'(1)) begin
                        state_nxt     = SCAN;
                        frame_cnt_nxt = '0;
                        pending_nxt   = 1'b0;
                        busy_nxt      = 1'b0;
                    end else begin
                        frame_cnt_nxt = frame_cnt - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = SCAN;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge Pclk) begin
        if (!rst_n) begin
            pending    <= 1'b0;
            cand_col   <= '0;
            cand_row   <= '0;
            frame_cnt  <= '0;
            hit        <= 1'b0;
            bullet_rst <= 1'b0;
            busy       <= 1'b0;
            hit_col    <= '0;
            hit_row    <= '0;
            score      <= '0;
        end else begin
            pending    <= pending_nxt;
            cand_col   <= cand_col_nxt;
            cand_row   <= cand_row_nxt;
            frame_cnt  <= frame_cnt_nxt;
            hit        <= hit_nxt;
            bullet_rst <= bullet_rst_nxt;
            busy       <= busy_nxt;
            hit_col    <= hit_col_nxt;
            hit_row    <= hit_row_nxt;
            score      <= score_nxt;
        end
    end

endmodule

// File: doc/bullet_hit_detector.md
BULLET_HIT_DETECTOR -- requirements
Module: bullet_hit_detector

Interface
REQ-001 The parameter list SHALL be: TRANSPARENT, default 8'h00, pixel value treated as empty sprite pixel.
REQ-002 The parameter list SHALL be: POINTS, default 10, score increment per confirmed hit.
REQ-003 The parameter list SHALL be: HOLDOFF_FRAMES, default 2, frames ignored after a hit (range 1-15).
REQ-004 The port list SHALL be, with clock and reset first:
- Pclk  in  1  25 MHz pixel clock.
- rst_n  in  1  synchronous, active-low reset.
REQ-005 The port list SHALL continue with the bullet-sprite and raster inputs:
- xx  in  10  current pixel x.
- yy  in  10  current pixel y.
- aactive  in  1  active-pixel strobe.
- BSpriteOn  in  1  bullet sprite coverage.
- dataout2  in  8  bullet pixel value.
REQ-006 The port list SHALL continue with the alien-sprite inputs:
- ASpriteOn  in  1  alien sprite coverage.
- alien_px  in  8  alien pixel value.
- alien_col  in  3  grid column of alien under pixel.
- alien_row  in  2  grid row of alien under pixel.
REQ-007 The port list SHALL end with the outputs:
- hit  out  1  one-cycle pulse on confirmed hit.
- bullet_rst  out  1  one-cycle request to return bullet to launcher.
- hit_col  out  3  column of last hit.
- hit_row  out  2  row of last hit.
- score  out  16  accumulated score.
- busy  out  1  high while in HOLDOFF.

Function
REQ-008 All inputs SHALL be treated as cycle-aligned: BSpriteOn/dataout2 and ASpriteOn/alien_px refer to the same pixel in the same cycle.
REQ-009 An overlap SHALL be defined as aactive=1, BSpriteOn=1, ASpriteOn=1, dataout2!=TRANSPARENT and alien_px!=TRANSPARENT, all in one cycle.
REQ-010 The FSM SHALL have three states: SCAN, REPORT and HOLDOFF; the reset state is SCAN.
REQ-011 In SCAN, the first overlap of a frame (raster order) SHALL set an internal pending flag and latch alien_col/alien_row into cand_col/cand_row; later overlaps in the same frame SHALL NOT change them.
REQ-012 Frame end SHALL be the cycle with xx==639 and yy==479; an overlap in that same cycle SHALL count for the current frame.
REQ-013 At frame end in SCAN with pending=1 (or set that cycle), the FSM SHALL move to REPORT; with pending=0 it SHALL stay in SCAN.
REQ-014 REPORT SHALL last exactly one cycle and SHALL do the following:
- drive hit=1 and bullet_rst=1.
- load hit_col/hit_row from cand.
- add POINTS to score.
- clear pending.
- load the frame counter with HOLDOFF_FRAMES.
- go to HOLDOFF.
REQ-015 Latency SHALL be exactly one Pclk cycle from the frame-end cycle to the hit pulse.
REQ-016 Score addition SHALL saturate: if score+POINTS>65535, score SHALL become 65535 and stay there.
REQ-017 In HOLDOFF, overlaps SHALL be ignored and busy=1; the counter SHALL decrement at each frame end; when it reaches 0 at a frame end, the FSM SHALL return to SCAN with pending=0.
REQ-018 hit and bullet_rst SHALL be 0 in every state except REPORT.
REQ-019 hit_col and hit_row SHALL hold their values until the next REPORT.
REQ-020 Overlaps with aactive=0 SHALL be ignored.

Reset
REQ-021 When rst_n=0 at a Pclk edge, the block SHALL enter SCAN and clear: hit, bullet_rst, hit_col, hit_row, score, busy, pending, cand_col, cand_row and the frame counter.
REQ-022 Reset SHALL have priority over all activity, including mid-REPORT and mid-HOLDOFF; a hit pending at reset SHALL be discarded.

Verification
REQ-023 Basic hit: overlap at (300,200) with col=3, row=1 -> one cycle after (639,479): hit=1, bullet_rst=1, hit_col=3, hit_row=1, score=10.
REQ-024 Multiple overlaps: overlaps at (300,200) with col=2 and at (310,205) with col=5 in one frame -> single hit pulse, hit_col=2, score +10 only.
REQ-025 Transparency: BSpriteOn=ASpriteOn=1 with dataout2=8'h00 for a whole frame -> no hit, score unchanged.
REQ-026 Holdoff: overlaps in frames N, N+1 and N+2 -> hit after N only, busy=1 through frames N+1 and N+2, and a hit after N+3 if an overlap occurs in frame N+3.
REQ-027 Saturation: score preloaded to 65530 via 6553 hits -> next hit gives score=65535; a further hit keeps score=65535.
REQ-028 Reset mid-HOLDOFF: rst_n=0 for one cycle during HOLDOFF -> busy=0, score=0, SCAN, and the next frame's overlap is reported normally.
